// File: rtl/adder_result_accumulator.sv
// Accumulates a programmed number of valid-qualified adder results ({cout,sum})
// into a saturating accumulator and flags completion with a one-cycle pulse.
module adder_result_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sum,
  input  logic              cout,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   w_targetNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [CNT_W-1:0]   w_cntInc;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_accNext;
  logic               r_ovf;
  logic               w_ovfNext;
  logic               r_busy;
  logic               r_valid;
  logic [ACC_W-1:0]   w_sample;
  logic [ACC_W:0]     w_sumWide;

  // One extra bit on the add exposes the carry used to detect saturation.
  assign w_sample  = {{(ACC_W-DATA_W-1){1'b0}}, cout, sum};
  assign w_sumWide = {1'b0, r_acc} + {1'b0, w_sample};
  assign w_cntInc  = r_cnt + CNT_W'(1);

  always_comb begin
    w_nextState  = r_state;
    w_targetNext = r_target;
    w_cntNext    = r_cnt;
    w_accNext    = r_acc;
    w_ovfNext    = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accNext = '0;
          w_cntNext = '0;
          w_ovfNext = 1'b0;
          if (num_samples != '0) begin
            w_targetNext = num_samples;
            w_nextState  = S_ACCUM;
          end else begin
            w_nextState  = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          w_cntNext = w_cntInc;
          if (w_sumWide[ACC_W]) begin
            w_accNext = '1;
            w_ovfNext = 1'b1;
          end else begin
            w_accNext = w_sumWide[ACC_W-1:0];
          end
          if (w_cntInc == r_target) begin
            w_nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // busy and acc_valid are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_target <= w_targetNext;
      r_cnt    <= w_cntNext;
      r_acc    <= w_accNext;
      r_ovf    <= w_ovfNext;
      r_busy   <= (w_nextState == S_ACCUM);
      r_valid  <= (w_nextState == S_DONE);
    end
  end

  assign busy       = r_busy;
  assign sample_cnt = r_cnt;
  assign acc_out    = r_acc;
  assign acc_valid  = r_valid;
  assign overflow   = r_ovf;

endmodule
